// File: rtl/iq_phase_freq_estimator_if.sv
// rtl/iq_phase_freq_estimator_if.sv - sample/result handshake bundle for iq_phase_freq_estimator (MAGNITUDE_OUT_EN adds magnitude)
interface iq_phase_freq_estimator_if #(
  parameter int DATA_BITWIDTH  = 8,
  parameter int DEPTH_BITWIDTH = 8
);
  logic                             in_valid;
  logic                             in_ready;
  logic signed [DATA_BITWIDTH-1:0]  i_in;
  logic signed [DATA_BITWIDTH-1:0]  q_in;
  logic                             out_valid;
  logic                             out_ready;
  logic        [DEPTH_BITWIDTH-1:0] phase;
  logic        [DEPTH_BITWIDTH-1:0] fword;
  logic                             first;
`ifdef MAGNITUDE_OUT_EN
  logic        [DATA_BITWIDTH:0]    magnitude;

  modport master (
    output in_valid, i_in, q_in, out_ready,
    input  in_ready, out_valid, phase, fword, first, magnitude
  );
  modport slave (
    input  in_valid, i_in, q_in, out_ready,
    output in_ready, out_valid, phase, fword, first, magnitude
  );
`else
  modport master (
    output in_valid, i_in, q_in, out_ready,
    input  in_ready, out_valid, phase, fword, first
  );
  modport slave (
    input  in_valid, i_in, q_in, out_ready,
    output in_ready, out_valid, phase, fword, first
  );
`endif
endinterface

// File: rtl/iq_phase_freq_estimator.sv
// rtl/iq_phase_freq_estimator.sv - iterative CORDIC vectoring: I/Q sample to phase word and phase increment
// Optional gain-compensated magnitude output enabled by MAGNITUDE_OUT_EN.
module iq_phase_freq_estimator #(
  parameter int DATA_BITWIDTH  = 8,
  parameter int DEPTH_BITWIDTH = 8,
  parameter int ITERATIONS     = DEPTH_BITWIDTH
) (
  input  logic                    clk,
  input  logic                    rstn,
  iq_phase_freq_estimator_if.slave bus
);
  localparam int XW = DATA_BITWIDTH + 2;
  localparam int ZW = DEPTH_BITWIDTH + 2;
  localparam int CW = $clog2(ITERATIONS + 2);
`ifdef MAGNITUDE_OUT_EN
  // The extra ROTATE step at iter == ITERATIONS is spent on the gain multiply.
  localparam int LAST_STEP = ITERATIONS;
  localparam int MAG_K     = $rtoi(0.60725 * (2.0 ** DATA_BITWIDTH) + 0.5);
`else
  localparam int LAST_STEP = ITERATIONS - 1;
`endif

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

  state_t state_q, state_d;

  logic signed [XW-1:0]             x_q, y_q, x_pre, y_pre, x_rot, y_rot, x_sh, y_sh;
  logic        [ZW-1:0]             z_q, z_pre, z_rot, z_fin;
  logic        [CW-1:0]             iter_q;
  logic                             zero_q;
  logic                             pending_q;
  logic                             first_q;
  logic        [DEPTH_BITWIDTH-1:0] phase_q, fword_q, prev_q, phase_new;
  logic                             accept, finish;

  // Angle table in internal z units (2 guard LSBs): a full turn is 2**ZW.
  function automatic logic [ZW-1:0] atan_word(input int k);
    real turns;
    turns = $atan(2.0 ** (-k)) / (2.0 * 3.141592653589793);
    return ZW'($rtoi(turns * (2.0 ** ZW) + 0.5));
  endfunction

  logic [ZW-1:0] atan_tab [2**CW];
  for (genvar g = 0; g < 2**CW; g++) begin : g_atan
    if (g < ITERATIONS) begin : g_used
      assign atan_tab[g] = atan_word(g);
    end else begin : g_pad
      assign atan_tab[g] = '0;
    end
  end

  assign accept = (state_q == IDLE) && bus.in_valid;
  assign finish = (state_q == ROTATE) && (iter_q == CW'(LAST_STEP));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = ROTATE;
      ROTATE:  if (iter_q == CW'(LAST_STEP)) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Left half-plane samples are turned by a half circle so the CORDIC only sees |angle| <= 90 deg.
  always_comb begin
    x_pre = XW'(bus.i_in);
    y_pre = XW'(bus.q_in);
    z_pre = '0;
    if (bus.i_in[DATA_BITWIDTH-1]) begin
      x_pre = -XW'(bus.i_in);
      y_pre = -XW'(bus.q_in);
      z_pre = {1'b1, {(ZW-1){1'b0}}};
    end
  end

  always_comb begin
    x_sh  = x_q >>> iter_q;
    y_sh  = y_q >>> iter_q;
    x_rot = x_q - y_sh;
    y_rot = y_q + x_sh;
    z_rot = z_q - atan_tab[iter_q];
    if (!y_q[XW-1]) begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + atan_tab[iter_q];
    end
  end

`ifdef MAGNITUDE_OUT_EN
  assign z_fin = z_q;
`else
  assign z_fin = z_rot;
`endif

  // Round away the guard bits; an all-zero sample has no angle and reports 0.
  assign phase_new = zero_q ? '0 : DEPTH_BITWIDTH'((z_fin + ZW'(2)) >> 2);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      iter_q    <= '0;
      zero_q    <= 1'b0;
      pending_q <= 1'b1;
      first_q   <= 1'b0;
      phase_q   <= '0;
      fword_q   <= '0;
      prev_q    <= '0;
    end else if (accept) begin
      x_q    <= x_pre;
      y_q    <= y_pre;
      z_q    <= z_pre;
      iter_q <= '0;
      zero_q <= (bus.i_in == '0) && (bus.q_in == '0);
    end else if (state_q == ROTATE) begin
      x_q    <= x_rot;
      y_q    <= y_rot;
      z_q    <= z_rot;
      iter_q <= iter_q + 1'b1;
      if (finish) begin
        phase_q   <= phase_new;
        fword_q   <= pending_q ? '0 : phase_new - prev_q;
        first_q   <= pending_q;
        pending_q <= 1'b0;
        prev_q    <= phase_new;
      end
    end
  end

`ifdef MAGNITUDE_OUT_EN
  logic [DATA_BITWIDTH:0]          mag_q;
  logic [XW+DATA_BITWIDTH-1:0]     mag_prod;

  // x is non-negative after pre-rotation, so the product can be taken unsigned.
  assign mag_prod = (XW+DATA_BITWIDTH)'($unsigned(x_q)) * (XW+DATA_BITWIDTH)'(MAG_K);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mag_q <= '0;
    end else if (finish) begin
      mag_q <= (DATA_BITWIDTH+1)'(mag_prod >> DATA_BITWIDTH);
    end
  end

  assign bus.magnitude = mag_q;
`endif

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.phase     = phase_q;
  assign bus.fword     = fword_q;
  assign bus.first     = first_q;
endmodule

// File: tb/tb_iq_phase_freq_estimator.sv
// tb/tb_iq_phase_freq_estimator.sv - directed self-checking bench for iq_phase_freq_estimator
module tb_iq_phase_freq_estimator;
  localparam int DW = 8;
  localparam int PW = 8;
`ifdef MAGNITUDE_OUT_EN
  localparam int LAT    = 10;
  localparam int PERIOD = 11;
`else
  localparam int LAT    = 9;
  localparam int PERIOD = 10;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   ph, fw, fi, lat;

  iq_phase_freq_estimator_if #(.DATA_BITWIDTH(DW), .DEPTH_BITWIDTH(PW)) bus ();

  iq_phase_freq_estimator #(.DATA_BITWIDTH(DW), .DEPTH_BITWIDTH(PW), .ITERATIONS(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Circular distance on the 8-bit phase wheel.
  task automatic chk_near(input string tag, input int obs, input int exp, input int tol);
    int d;
    d = (obs - exp) & 255;
    if (d > 128) d = 256 - d;
    tests++;
    assert (d <= tol) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (+/-%0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic start(input int i, input int q);
    int n;
    bus.i_in = DW'(i);
    bus.q_in = DW'(q);
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_timeout", int'(bus.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    lat = 1;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      lat++;
      n++;
    end
    chk("out_valid_timeout", int'(bus.out_valid), 1);
    ph = int'(bus.phase);
    fw = int'(bus.fword);
    fi = int'(bus.first);
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic do_send(input int i, input int q);
    start(i, q);
    wait_out();
    accept();
  endtask

  initial begin
    int hs[5];
    int prev_ph, held;
    real ang;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.i_in = '0;
    bus.q_in = '0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_phase", int'(bus.phase), 0);
    chk("rst_fword", int'(bus.fword), 0);
    rstn = 1'b1;
    @(negedge clk);

    // Four cardinal directions.
    do_send(100, 0);
    chk("latency", lat, LAT);
    chk_near("card0_phase", ph, 0, 1);
    chk("card0_first", fi, 1);
    chk("card0_fword", fw, 0);
    do_send(0, 100);
    chk_near("card1_phase", ph, 64, 1);
    chk("card1_first", fi, 0);
    chk_near("card1_fword", fw, 64, 2);
    do_send(-100, 0);
    chk_near("card2_phase", ph, 128, 1);
    chk_near("card2_fword", fw, 64, 2);
    do_send(0, -100);
    chk_near("card3_phase", ph, 192, 1);
    chk("card3_first", fi, 0);
    prev_ph = ph;

    // Most negative corner and the degenerate origin.
    do_send(-128, -128);
    chk_near("corner_phase", ph, 160, 1);
    chk("corner_fword", fw, (ph - prev_ph) & 255);
    prev_ph = ph;
    do_send(0, 0);
    chk("origin_phase", ph, 0);
    chk("origin_fword", fw, (0 - prev_ph) & 255);
    prev_ph = ph;

    // DDS-style sweep, fword 5, wraps 255 -> 4.
    for (int n = 0; n < 60; n++) begin
      ang = 2.0 * 3.141592653589793 * real'((5 * n) % 256) / 256.0;
      do_send(int'(100.0 * $cos(ang)), int'(100.0 * $sin(ang)));
      chk_near($sformatf("sweep%0d_phase", n), ph, (5 * n) % 256, 1);
      chk($sformatf("sweep%0d_fword_rel", n), fw, (ph - prev_ph) & 255);
      if (n > 0) chk_near($sformatf("sweep%0d_fword", n), fw, 5, 2);
      prev_ph = ph;
    end

    // Back-pressure in DONE: outputs hold and a new sample is refused.
    start(50, 50);
    wait_out();
    held = ph;
    chk_near("hold_phase", held, 32, 1);
    bus.i_in = DW'(-100);
    bus.q_in = DW'(0);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_out_valid", k), int'(bus.out_valid), 1);
      chk($sformatf("hold%0d_in_ready", k), int'(bus.in_ready), 0);
      chk($sformatf("hold%0d_phase", k), int'(bus.phase), held);
    end
    bus.in_valid = 1'b0;
    accept();
    chk("release_out_valid", int'(bus.out_valid), 0);
    chk("release_in_ready", int'(bus.in_ready), 1);

    // Reset while rotating aborts the sample and re-arms first.
    start(30, 40);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", int'(bus.in_ready), 1);
    chk("abort_out_valid", int'(bus.out_valid), 0);
    rstn = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_partial", int'(bus.out_valid), 0);
    do_send(0, 100);
    chk_near("abort_phase", ph, 64, 1);
    chk("abort_first", fi, 1);
    chk("abort_fword", fw, 0);

    // Continuous streaming: handshake spacing.
    bus.i_in = DW'(70);
    bus.q_in = DW'(-70);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int n;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      hs[k] = cyc;
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    for (int k = 1; k < 5; k++) chk($sformatf("stream%0d_period", k), hs[k] - hs[k-1], PERIOD);
    repeat (PERIOD + 2) @(negedge clk);
    bus.out_ready = 1'b0;
    chk("stream_idle", int'(bus.in_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
